// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: user write port and transmitter handshake of the UART TX feeder
interface uart_tx_feeder_if #(parameter int DEPTH_LOG2 = 4);
  logic [15:0] WR_DATA;
  logic WR_EN;
  logic FLUSH;
  logic FULL;
  logic EMPTY;
  logic [DEPTH_LOG2:0] LEVEL;
  logic [15:0] TX_DATA;
  logic TX_DATA_VAL;
  logic TX_BUSY;
  logic OVF;
  logic OVF_CLR;
  modport master (
    output WR_DATA, WR_EN, FLUSH, TX_BUSY, OVF_CLR,
    input FULL, EMPTY, LEVEL, TX_DATA, TX_DATA_VAL, OVF
  );
  modport slave (
    input WR_DATA, WR_EN, FLUSH, TX_BUSY, OVF_CLR,
    output FULL, EMPTY, LEVEL, TX_DATA, TX_DATA_VAL, OVF
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: word FIFO feeding a UART transmitter via launch/ack handshake.
// Define UART_TX_FEEDER_OVF_FLAG_EN to build the sticky overflow flag.
module uart_tx_feeder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input logic CLK,
  input logic RST,
  uart_tx_feeder_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int AW = DEPTH_LOG2 + 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, ACK, DRAIN} state_t;
  state_t state, state_nxt;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, level, level_nxt;
  logic [CW-1:0] ack_cnt;
  logic [15:0] tx_data;
  logic full, empty, push, pop, ack_done, tx_val;
  assign push = bus.WR_EN && !full && !bus.FLUSH;
  assign pop = state == IDLE && !empty && !bus.TX_BUSY;
  assign ack_done = ack_cnt == CW'(ACK_TIMEOUT - 1);
  assign level_nxt = bus.FLUSH ? '0 : level + AW'(push) - AW'(pop);
  always_ff @(posedge CLK)
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.WR_DATA;
  // flush clears the queue only; a word already popped still launches
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      ack_cnt <= '0;
      tx_val <= 1'b0;
      tx_data <= '0;
    end else begin
      wr_ptr <= bus.FLUSH ? '0 : wr_ptr + AW'(push);
      rd_ptr <= bus.FLUSH ? '0 : rd_ptr + AW'(pop);
      level <= level_nxt;
      full <= level_nxt == AW'(DEPTH);
      empty <= level_nxt == '0;
      ack_cnt <= state == ACK && !bus.TX_BUSY ? ack_cnt + 1'b1 : '0;
      tx_val <= state == LAUNCH;
      if (pop) tx_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
    end
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE   ? (pop ? LAUNCH : IDLE) :
                state == LAUNCH ? ACK :
                state == ACK    ? (bus.TX_BUSY ? DRAIN : ack_done ? IDLE : ACK) :
                                  (bus.TX_BUSY ? DRAIN : IDLE);
  end
  assign bus.FULL = full;
  assign bus.EMPTY = empty;
  assign bus.LEVEL = level;
  assign bus.TX_DATA = tx_data;
  assign bus.TX_DATA_VAL = tx_val;
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
  logic ovf;
  always_ff @(posedge CLK or posedge RST)
    if (RST) ovf <= 1'b0;
    else ovf <= !bus.OVF_CLR && (ovf || (bus.WR_EN && full && !bus.FLUSH));
  assign bus.OVF = ovf;
`else
  assign bus.OVF = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: table vectors, directed corner sequences and random traffic vs a queue model
module tb_uart_tx_feeder;
  localparam int DL = 4;
  localparam int DEPTH = 16;
  localparam int TO = 4;
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif
  typedef struct {
    logic we;
    logic [15:0] d;
    logic clr;
    logic acc;
    int lvl;
    logic full;
    logic ovf;
  } vec_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  uart_tx_feeder_if #(.DEPTH_LOG2(DL)) bus ();
  uart_tx_feeder #(.DEPTH_LOG2(DL), .ACK_TIMEOUT(TO)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  logic force_busy = 1'b1;
  logic model_busy = 1'b0;
  int mode = 0;
  assign bus.TX_BUSY = force_busy | model_busy;
  logic [15:0] exp_q[$];
  int st_q[$];
  int cyc = 0;
  int strobes = 0;
  int left = 0;
  bit pending = 0;
  bit prev_val = 0;
  vec_t tbl[20];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic wr(input logic [15:0] d);
    bus.WR_EN = 1'b1;
    bus.WR_DATA = d;
    tick();
    bus.WR_EN = 1'b0;
  endtask
  task automatic settle();
    int n = 0;
    while (model_busy && n < 40) begin
      tick();
      n++;
    end
    tick(TO + 4);
  endtask
  task automatic wait_drain(input string nm, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk(nm, exp_q.size(), 0);
    settle();
  endtask
  always @(posedge CLK) cyc++;
  // transmitter model: busy rises the cycle after each strobe; strobes scored against exp_q
  always @(negedge CLK) begin
    int r;
    if (RST) begin
      pending = 0;
      left = 0;
      model_busy = 1'b0;
      prev_val = 0;
    end else begin
      if (bus.TX_DATA_VAL) begin
        strobes++;
        st_q.push_back(cyc);
        chk("no_back_to_back", prev_val, 0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got data %0h, expected no strobe", bus.TX_DATA);
        end else chk("strobe_data", bus.TX_DATA, exp_q.pop_front());
      end
      prev_val = bus.TX_DATA_VAL;
      if (left > 0) begin
        left--;
        if (left == 0) model_busy = 1'b0;
      end
      if (pending) begin
        r = mode == 0 ? 10 : mode == 2 ? $urandom_range(0, 6) : 0;
        if (r > 0) begin
          model_busy = 1'b1;
          left = r;
        end
      end
      pending = bus.TX_DATA_VAL;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int sb;
    int n;
    logic [15:0] d;
    for (int i = 0; i < 20; i++)
      tbl[i] = i < 16 ? '{1'b1, 16'(i), 1'b0, 1'b1, i + 1, i == 15, 1'b0} :
               i == 16 ? '{1'b1, 16'hDEAD, 1'b0, 1'b0, 16, 1'b1, OVF_ON} :
               i == 17 ? '{1'b0, 16'h0000, 1'b0, 1'b0, 16, 1'b1, OVF_ON} :
               i == 18 ? '{1'b1, 16'hBEEF, 1'b1, 1'b0, 16, 1'b1, 1'b0} :
                         '{1'b0, 16'h0000, 1'b0, 1'b0, 16, 1'b1, 1'b0};
    bus.WR_EN = 1'b0;
    bus.WR_DATA = '0;
    bus.FLUSH = 1'b0;
    bus.OVF_CLR = 1'b0;
    tick(3);
    chk("rst_level", bus.LEVEL, 0);
    chk("rst_empty", bus.EMPTY, 1);
    chk("rst_full", bus.FULL, 0);
    chk("rst_tx_data", bus.TX_DATA, 0);
    chk("rst_val", bus.TX_DATA_VAL, 0);
    chk("rst_ovf", bus.OVF, 0);
    RST = 1'b0;
    force_busy = 1'b0;
    tick(2);
    exp_q.push_back(16'h0041);
    wr(16'h0041);
    chk("lat_level", bus.LEVEL, 1);
    tick();
    chk("lat_val_k1", bus.TX_DATA_VAL, 0);
    tick();
    chk("lat_val_k2", bus.TX_DATA_VAL, 1);
    chk("lat_data_k2", bus.TX_DATA, 16'h0041);
    chk("lat_empty_k2", bus.EMPTY, 1);
    tick();
    chk("lat_val_k3", bus.TX_DATA_VAL, 0);
    settle();
    force_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.WR_EN = tbl[i].we;
      bus.WR_DATA = tbl[i].d;
      bus.OVF_CLR = tbl[i].clr;
      if (tbl[i].acc) exp_q.push_back(tbl[i].d);
      tick();
      bus.WR_EN = 1'b0;
      bus.OVF_CLR = 1'b0;
      chk($sformatf("tbl%0d_level", i), bus.LEVEL, tbl[i].lvl);
      chk($sformatf("tbl%0d_full", i), bus.FULL, tbl[i].full);
      chk($sformatf("tbl%0d_empty", i), bus.EMPTY, tbl[i].lvl == 0);
      chk($sformatf("tbl%0d_ovf", i), bus.OVF, tbl[i].ovf);
    end
    sb = strobes;
    mode = 0;
    force_busy = 1'b0;
    wait_drain("drain16", 16 * 20 + 50);
    chk("drain16_count", strobes - sb, 16);
    chk("drain16_level", bus.LEVEL, 0);
    chk("drain16_empty", bus.EMPTY, 1);
    mode = 1;
    st_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(16'h0100 + 16'(i));
      wr(16'h0100 + 16'(i));
    end
    wait_drain("timeout_drain", 100);
    chk("timeout_count", st_q.size(), 3);
    if (st_q.size() == 3) begin
      chk("timeout_gap0", st_q[1] - st_q[0], TO + 2);
      chk("timeout_gap1", st_q[2] - st_q[1], TO + 2);
    end
    mode = 0;
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) wr(16'h0200 + 16'(i));
    chk("flush_pre_level", bus.LEVEL, 5);
    bus.FLUSH = 1'b1;
    bus.WR_EN = 1'b1;
    bus.WR_DATA = 16'h0777;
    tick();
    bus.FLUSH = 1'b0;
    bus.WR_EN = 1'b0;
    chk("flush_level", bus.LEVEL, 0);
    chk("flush_empty", bus.EMPTY, 1);
    chk("flush_full", bus.FULL, 0);
    chk("flush_ovf", bus.OVF, 0);
    sb = strobes;
    force_busy = 1'b0;
    tick(30);
    chk("flush_no_strobe", strobes - sb, 0);
    exp_q.push_back(16'h0A00);
    for (int i = 0; i < 4; i++) wr(16'h0A00 + 16'(i));
    n = 0;
    while (!model_busy && n < 20) begin
      tick();
      n++;
    end
    chk("rst_mid_busy_seen", model_busy, 1);
    tick(2);
    chk("rst_mid_level", bus.LEVEL, 3);
    #2 RST = 1'b1;
    #1;
    chk("arst_level", bus.LEVEL, 0);
    chk("arst_empty", bus.EMPTY, 1);
    chk("arst_full", bus.FULL, 0);
    chk("arst_tx_data", bus.TX_DATA, 0);
    chk("arst_val", bus.TX_DATA_VAL, 0);
    chk("arst_ovf", bus.OVF, 0);
    exp_q.delete();
    tick(2);
    RST = 1'b0;
    sb = strobes;
    tick(30);
    chk("arst_no_strobe", strobes - sb, 0);
    exp_q.push_back(16'h1234);
    wr(16'h1234);
    wait_drain("arst_new_word", 50);
    mode = 2;
    repeat (600) begin
      if (exp_q.size() < DEPTH && $urandom_range(0, 2) == 0) begin
        d = 16'($urandom);
        exp_q.push_back(d);
        bus.WR_EN = 1'b1;
        bus.WR_DATA = d;
      end
      tick();
      bus.WR_EN = 1'b0;
    end
    wait_drain("rand_drain", 800);
    chk("rand_empty", bus.EMPTY, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: FIFO depth = 2**DEPTH_LOG2 words.
REQ-002 Parameter ACK_TIMEOUT, default 4: max cycles to wait for TX_BUSY rise after a launch.
REQ-003 CLK  input  1  clock; all logic on posedge CLK.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 WR_DATA  input  16  user word to queue.
REQ-006 WR_EN  input  1  write strobe, one word per cycle.
REQ-007 FLUSH  input  1  discard all queued words.
REQ-008 FULL  output  1  FIFO full, registered.
REQ-009 EMPTY  output  1  FIFO empty, registered.
REQ-010 LEVEL  output  DEPTH_LOG2+1  queued word count.
REQ-011 TX_DATA  output  16  word to transmitter, registered.
REQ-012 TX_DATA_VAL  output  1  one-cycle launch strobe to transmitter.
REQ-013 TX_BUSY  input  1  transmitter busy; includes CTS flow control.
REQ-014 OVF  output  1  sticky overflow flag (see Configuration).
REQ-015 OVF_CLR  input  1  clears OVF.

Function
REQ-016 FIFO SHALL store words in write order, circular pointers of DEPTH_LOG2+1 bits, wrap at depth.
REQ-017 WR_EN with FULL=0 SHALL store WR_DATA and increment LEVEL next cycle; WR_EN with FULL=1 SHALL drop the word.
REQ-018 FULL is the registered value, so a write while FULL=1 SHALL be dropped even if a pop occurs in the same cycle.
REQ-019 Write and pop in the same cycle with FULL=0 SHALL leave LEVEL unchanged.
REQ-020 FLUSH SHALL zero pointers and LEVEL next cycle, set EMPTY=1 and FULL=0, and override a same-cycle WR_EN (dropped, not an overflow); an in-flight word is unaffected.
REQ-021 FSM states SHALL be IDLE, LAUNCH, ACK and DRAIN.
REQ-022 IDLE->LAUNCH when EMPTY=0 and TX_BUSY=0: load TX_DATA from head and pop.
REQ-023 LAUNCH SHALL assert TX_DATA_VAL for exactly one cycle, then go to ACK.
REQ-024 ACK->DRAIN when TX_BUSY=1; ACK->IDLE after ACK_TIMEOUT cycles with TX_BUSY=0 (word deemed sent).
REQ-025 DRAIN->IDLE when TX_BUSY=0.
REQ-026 TX_DATA SHALL hold its value from LAUNCH until the next LAUNCH.
REQ-027 Latency: write at edge k into an empty FIFO with FSM in IDLE and TX_BUSY=0 SHALL give TX_DATA_VAL=1 in the cycle after edge k+2.
REQ-028 TX_DATA_VAL SHALL never be asserted in two consecutive cycles or while TX_BUSY=1 was sampled in IDLE.

Reset
REQ-029 RST=1 SHALL asynchronously force: state IDLE, pointers 0, LEVEL=0, EMPTY=1, FULL=0, TX_DATA=0, TX_DATA_VAL=0, OVF=0.
REQ-030 Reset mid-transfer SHALL abandon the in-flight word and discard all queued words; no TX_DATA_VAL until new writes arrive after release.

Configuration
REQ-031 With macro UART_TX_FEEDER_OVF_FLAG_EN defined: OVF SHALL set on any dropped write under REQ-017 and stay set until OVF_CLR=1 (clear wins over a same-cycle set).
REQ-032 Without UART_TX_FEEDER_OVF_FLAG_EN: OVF SHALL be tied 0, OVF_CLR ignored, no overflow logic built.

Verification
REQ-033 Write 0x0041 into empty FIFO, TX_BUSY=0 -> TX_DATA_VAL pulse 1 cycle with TX_DATA=0x0041 at edge k+2; EMPTY back to 1.
REQ-034 Write 16 words 0x0000..0x000F while TX_BUSY=1 -> FULL=1, LEVEL=16; 17th write dropped; OVF=1 only if UART_TX_FEEDER_OVF_FLAG_EN.
REQ-035 Release TX_BUSY, model busy rising 1 cycle after each strobe and lasting 10 cycles -> 16 strobes in order 0x0000..0x000F, one per busy episode.
REQ-036 TX_BUSY never rises after a strobe -> FSM returns to IDLE after 4 cycles and launches the next word.
REQ-037 Queue 5 words, assert FLUSH with WR_EN=1 -> LEVEL=0, EMPTY=1, no further strobes, OVF unchanged.
REQ-038 Assert RST in DRAIN with LEVEL=3 -> all outputs at reset values; no strobe after release until a new write.
